// File: rtl/div16_seq.sv
// Iterative restoring divider: one quotient bit per cycle, signed ops via magnitudes plus sign fixup.
// Normal divide: done 17 edges after the start edge; divide-by-zero: done in the cycle after start.
module div16_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic             dbz_q, dbz_d;

   logic             div_zero;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dsr_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             fits;

   assign div_zero = (divisor == '0);
   assign dvd_mag  = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
   assign dsr_mag  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

   // The remainder stays below the divisor, so WIDTH bits hold it; only the shifted trial needs one more.
   assign shifted  = {rem_q, dvd_q[WIDTH-1]};
   assign fits     = (shifted >= {1'b0, dsr_q});
   assign diff     = shifted[WIDTH-1:0] - dsr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = div_zero ? DONE : CALC;
         CALC:    if (cnt_q == LAST_CNT) state_d = FIXUP;
         FIXUP:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;

   always_comb begin
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (div_zero) begin
                  quo_d = '1;
                  rmd_d = dividend;
                  dbz_d = 1'b1;
               end else begin
                  dvd_d   = dvd_mag;
                  dsr_d   = dsr_mag;
                  q_neg_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg_d = signed_op & dividend[WIDTH-1];
                  rem_d   = '0;
                  cnt_d   = '0;
                  dbz_d   = 1'b0;
               end
            end
         end
         CALC: begin
            rem_d = fits ? diff : shifted[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], fits};
            cnt_d = cnt_q + 1'b1;
         end
         FIXUP: begin
            quo_d = q_neg_q ? -dvd_q : dvd_q;
            rmd_d = r_neg_q ? -rem_q : rem_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dvd_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
      end
   end

endmodule

// File: tb/tb_div16_seq.sv
// Scoreboard bench for div16_seq: expected results are queued at issue and compared on done.
module tb_div16_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        signed_op;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] r;
      logic        z;
   } res_t;

   res_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   t_start  = 0;

   div16_seq #(.WIDTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .signed_op  (signed_op),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic res_t model(input logic sop, input logic [15:0] a, input logic [15:0] b);
      res_t m;
      int   sa;
      int   sbv;
      if (b == 16'd0) begin
         m.q = 16'hFFFF;
         m.r = a;
         m.z = 1'b1;
      end else if (sop) begin
         sa  = $signed(a);
         sbv = $signed(b);
         m.q = 16'(sa / sbv);
         m.r = 16'(sa % sbv);
         m.z = 1'b0;
      end else begin
         m.q = a / b;
         m.r = a % b;
         m.z = 1'b0;
      end
      return m;
   endfunction

   // Call at a negedge; returns at the negedge after the sampling edge with t_start = that edge's count.
   task automatic issue(input logic sop, input logic [15:0] a, input logic [15:0] b, input bit push);
      signed_op = sop;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      t_start   = cyc;
      if (push) exp_q.push_back(model(sop, a, b));
      signed_op = 1'($urandom);
      dividend  = 16'($urandom);
      divisor   = 16'($urandom);
   endtask

   task automatic wait_done(output bit to);
      to = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      signed_op = 1'b0;
      dividend = 16'd0;
      divisor = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
         failures++;
         $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h z=%b, want all zero",
                  busy, done, quotient, remainder, div_by_zero);
      end
      reset = 1'b0;
   endtask

   task automatic test_unsigned();
      logic [15:0] ta[5] = '{16'd100, 16'hFFFF, 16'hFFFF, 16'h8000, 16'd5};
      logic [15:0] tb[5] = '{16'd7,   16'h0001, 16'hFFFF, 16'hFFFF, 16'd9};
      res_t e, got;
      bit   to;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         issue(1'b0, ta[i], tb[i], 1'b1);
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL unsigned_busy[%0d]: got %b, want 1", i, busy);
         end
         wait_done(to);
         e = exp_q.pop_front();
         checks++;
         if (to) begin
            failures++;
            $display("FAIL unsigned_timeout[%0d]: done not seen in 40 cycles, want done", i);
         end else begin
            got = {quotient, remainder, div_by_zero};
            if (got !== e) begin
               failures++;
               $display("FAIL unsigned_result[%0d]: got q=%h r=%h z=%b, want q=%h r=%h z=%b",
                        i, got.q, got.r, got.z, e.q, e.r, e.z);
            end
            checks++;
            if (cyc - t_start !== 17) begin
               failures++;
               $display("FAIL unsigned_latency[%0d]: got %0d, want 17", i, cyc - t_start);
            end
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b00 || {quotient, remainder, div_by_zero} !== e) begin
               failures++;
               $display("FAIL unsigned_after_done[%0d]: got busy=%b done=%b q=%h r=%h, want 0 0 %h %h",
                        i, busy, done, quotient, remainder, e.q, e.r);
            end
         end
      end
   endtask

   task automatic test_signed();
      logic [15:0] ta[5] = '{16'hFFF9, 16'h0007, 16'h8000, 16'hFFF9, 16'h8000};
      logic [15:0] tb[5] = '{16'h0002, 16'hFFFE, 16'hFFFF, 16'hFFFE, 16'h0001};
      res_t e, got;
      bit   to;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         issue(1'b1, ta[i], tb[i], 1'b1);
         wait_done(to);
         e = exp_q.pop_front();
         checks++;
         if (to) begin
            failures++;
            $display("FAIL signed_timeout[%0d]: done not seen in 40 cycles, want done", i);
         end else begin
            got = {quotient, remainder, div_by_zero};
            if (got !== e) begin
               failures++;
               $display("FAIL signed_result[%0d]: got q=%h r=%h z=%b, want q=%h r=%h z=%b",
                        i, got.q, got.r, got.z, e.q, e.r, e.z);
            end
         end
      end
   endtask

   task automatic test_div_zero();
      res_t e, got;
      bit   to;
      for (int m = 0; m < 2; m++) begin
         @(negedge clk);
         issue(1'(m), 16'h1234, 16'h0000, 1'b1);
         wait_done(to);
         e = exp_q.pop_front();
         checks++;
         if (to) begin
            failures++;
            $display("FAIL dz_timeout[%0d]: done not seen in 40 cycles, want done", m);
         end else begin
            got = {quotient, remainder, div_by_zero};
            if (got !== e || cyc - t_start !== 0) begin
               failures++;
               $display("FAIL dz_result[%0d]: got q=%h r=%h z=%b lat=%0d, want q=%h r=%h z=%b lat=0",
                        m, got.q, got.r, got.z, cyc - t_start, e.q, e.r, e.z);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || {quotient, remainder, div_by_zero} !== e) begin
               failures++;
               $display("FAIL dz_hold[%0d]: got done=%b q=%h r=%h z=%b, want done=0 q=%h r=%h z=%b",
                        m, done, quotient, remainder, div_by_zero, e.q, e.r, e.z);
            end
         end
         issue(1'(m), 16'd10, 16'd3, 1'b1);
         wait_done(to);
         e = exp_q.pop_front();
         checks++;
         got = {quotient, remainder, div_by_zero};
         if (to || got !== e) begin
            failures++;
            $display("FAIL dz_followup[%0d]: got timeout=%b q=%h r=%h z=%b, want q=%h r=%h z=%b",
                     m, to, got.q, got.r, got.z, e.q, e.r, e.z);
         end
      end
   endtask

   task automatic test_ignore_start();
      res_t e, got;
      bit   to;
      @(negedge clk);
      issue(1'b0, 16'd100, 16'd7, 1'b1);
      repeat (3) @(negedge clk);
      signed_op = 1'b1;
      dividend  = 16'h7777;
      divisor   = 16'h0003;
      start     = 1'b1;
      wait_done(to);
      e = exp_q.pop_front();
      checks++;
      got = {quotient, remainder, div_by_zero};
      if (to || got !== e || cyc - t_start !== 17) begin
         failures++;
         $display("FAIL ignore_calc: got timeout=%b q=%h r=%h lat=%0d, want q=%h r=%h lat=17",
                  to, got.q, got.r, cyc - t_start, e.q, e.r);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL ignore_done_cycle: got busy=%b, want 0 (start in done cycle accepted)", busy);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || {quotient, remainder, div_by_zero} !== e) begin
            failures++;
            $display("FAIL ignore_hold[%0d]: got done=%b q=%h r=%h, want done=0 q=%h r=%h",
                     i, done, quotient, remainder, e.q, e.r);
         end
      end
   endtask

   task automatic test_back_to_back();
      res_t e, got;
      bit   to;
      int   start_cyc;
      @(negedge clk);
      issue(1'b0, 16'd1000, 16'd10, 1'b1);
      wait_done(to);
      e = exp_q.pop_front();
      checks++;
      got = {quotient, remainder, div_by_zero};
      if (to || got !== e) begin
         failures++;
         $display("FAIL b2b_first: got timeout=%b q=%h r=%h, want q=%h r=%h", to, got.q, got.r, e.q, e.r);
      end
      @(negedge clk);
      start_cyc = cyc;
      issue(1'b1, 16'hFF9C, 16'd7, 1'b1);
      wait_done(to);
      e = exp_q.pop_front();
      checks++;
      got = {quotient, remainder, div_by_zero};
      if (to || got !== e) begin
         failures++;
         $display("FAIL b2b_second: got timeout=%b q=%h r=%h, want q=%h r=%h", to, got.q, got.r, e.q, e.r);
      end
      checks++;
      if (cyc - start_cyc !== 18) begin
         failures++;
         $display("FAIL b2b_latency: got %0d cycles from start cycle to done, want 18", cyc - start_cyc);
      end
   endtask

   task automatic test_reset_mid();
      res_t e, got;
      bit   to;
      bit   seen;
      @(negedge clk);
      issue(1'b0, 16'd100, 16'd7, 1'b0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
         failures++;
         $display("FAIL reset_mid_state: got busy=%b done=%b q=%h r=%h z=%b, want all zero",
                  busy, done, quotient, remainder, div_by_zero);
      end
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_no_done: got done pulse=%b, want 0", seen);
      end
      issue(1'b0, 16'd50, 16'd5, 1'b1);
      wait_done(to);
      e = exp_q.pop_front();
      checks++;
      got = {quotient, remainder, div_by_zero};
      if (to || got !== e) begin
         failures++;
         $display("FAIL reset_mid_after: got timeout=%b q=%h r=%h z=%b, want q=%h r=%h z=%b",
                  to, got.q, got.r, got.z, e.q, e.r, e.z);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
